// File: rtl/led_link_pkg.sv
// Shared definitions for the LED serial link: FSM state encoding and the
// default frame geometry used by both the master and slave-side benches.
package led_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } link_state_t;

  localparam int LED_DATA_W  = 4;
  localparam int LED_CLK_DIV = 2;

endpackage

// File: rtl/serial_led_master_if.sv
// System-side request/response and serial-side pins of the LED link master,
// bundled so the master and its environment agree on directions.
interface serial_led_master_if
  import led_link_pkg::*;
#(
  parameter int DATA_W = LED_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              select;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output sclk, mosi, select, busy, done, rx_data
  );

  modport slave (
    output start, tx_data, miso,
    input  sclk, mosi, select, busy, done, rx_data
  );

endinterface

// File: rtl/sclk_tick_gen.sv
// Half-period timer for the serial clock: phase_end marks the last system
// cycle of each CLK_DIV-long phase; clr restarts the phase on state entry.
module sclk_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic phase_end
);

  localparam int PH_W = $clog2(CLK_DIV) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  assign phase_end = (phase_q == PH_LAST);

  // Next phase count: restart on clear or at the end of a half period.
  always_comb begin
    phase_d = phase_q;
    if (clr || phase_end) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/serial_led_master.sv
// LED link master: serializes a parallel word MSB-first on a divided clock
// under an active-low select, appending one commit edge, and captures miso.
module serial_led_master
  import led_link_pkg::*;
#(
  parameter int DATA_W  = LED_DATA_W,
  parameter int CLK_DIV = LED_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst,
  serial_led_master_if.master bus
);

  localparam int BIT_W = $clog2(DATA_W + 1) + 1;
  localparam logic [BIT_W-1:0] BIT_COMMIT   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST_DAT = BIT_W'(DATA_W - 1);

  link_state_t       state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              select_q, select_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              phase_end;
  logic              tick_clr;
  logic              in_frame;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (tick_clr),
    .phase_end (phase_end)
  );

  // Next-state, shift-register and bit-index logic.
  always_comb begin
    state_d = state_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SETUP;
          tx_sr_d = bus.tx_data;
          bit_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_d = ST_HIGH;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          state_d = ST_LOW;
          tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (!phase_end) begin
          state_d = ST_LOW;
        end else if (bit_q == BIT_COMMIT) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_HIGH;
          bit_d   = bit_q + BIT_W'(1);
          // The commit edge carries no return data, so miso is not sampled.
          if (bit_q < BIT_LAST_DAT) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
          end else begin
            rx_sr_d = rx_sr_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    in_frame  = (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW);
    tick_clr  = (state_d != state_q);
    sclk_d    = (state_d == ST_HIGH);
    select_d  = !in_frame;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    mosi_d    = in_frame ? tx_sr_d[DATA_W-1] : 1'b0;
    rx_data_d = (state_d == ST_DONE) ? rx_sr_q : rx_data_q;
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      select_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      select_q  <= select_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.select  = select_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_serial_led_master.sv
// Scoreboard bench for serial_led_master: default geometry instance plus an
// 8-bit, CLK_DIV=1 instance, each checked against a frame-level model.
module tb_serial_led_master;
  import led_link_pkg::*;

  localparam int DW_A = LED_DATA_W;
  localparam int CD_A = LED_CLK_DIV;
  localparam int DW_B = 8;
  localparam int CD_B = 1;
  // Frame length: setup phase, then DATA_W+1 full serial clock periods.
  localparam int T_A = 1 + CD_A + 2 * CD_A * (DW_A + 1);
  localparam int T_B = 1 + CD_B + 2 * CD_B * (DW_B + 1);

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a, e_b;
  logic a_loop, a_const, b_loop, b_const;

  serial_led_master_if #(.DATA_W(DW_A)) if_a ();
  serial_led_master_if #(.DATA_W(DW_B)) if_b ();

  serial_led_master #(.DATA_W(DW_A), .CLK_DIV(CD_A)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  serial_led_master #(.DATA_W(DW_B), .CLK_DIV(CD_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.miso = a_loop ? if_a.mosi : a_const;
  assign if_b.miso = b_loop ? if_b.mosi : b_const;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: collect the serial stream, run a behavioural slave, check at done.
  int a_rises, a_obs, a_shift, a_led, a_sel_lo, a_viol;
  logic a_prev_sclk;
  always @(negedge clk) begin
    if (rst) begin
      a_rises = 0; a_obs = 0; a_shift = 0; a_led = 0; a_sel_lo = 0; a_viol = 0;
      a_prev_sclk = 1'b0;
    end else begin
      if (if_a.sclk && if_a.select) a_viol = 1;
      if (!if_a.select) a_sel_lo++;
      if (if_a.sclk && !a_prev_sclk && !if_a.select) begin
        a_rises++;
        a_obs   = (a_obs << 1) | int'(if_a.mosi);
        a_led   = a_shift;
        a_shift = ((a_shift << 1) | int'(if_a.mosi)) & ((1 << DW_A) - 1);
      end
      a_prev_sclk = if_a.sclk;
      if (if_a.done) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_done: got done=1 want no frame (cycle %0d)", cyc);
        end else begin
          e_a = exp_a.pop_front();
          chk("a_rx_data", 32'(if_a.rx_data), 32'(e_a.rx));
          chk("a_done_cycle", cyc, e_a.done_cyc);
          chk("a_sclk_rises", a_rises, DW_A + 1);
          chk("a_mosi_stream", a_obs, 32'({e_a.tx, 1'b0}));
          chk("a_slave_led", a_led, 32'(e_a.tx));
          chk("a_select_low_len", a_sel_lo, T_A - 1);
          chk("a_select_under_sclk", a_viol, 0);
        end
        a_rises = 0; a_obs = 0; a_shift = 0; a_led = 0; a_sel_lo = 0; a_viol = 0;
      end
    end
  end

  // Monitor B: serial stream and completion checks for the 8-bit instance.
  int b_rises, b_obs;
  logic b_prev_sclk;
  always @(negedge clk) begin
    if (rst) begin
      b_rises = 0; b_obs = 0; b_prev_sclk = 1'b0;
    end else begin
      if (if_b.sclk && !b_prev_sclk && !if_b.select) begin
        b_rises++;
        b_obs = (b_obs << 1) | int'(if_b.mosi);
      end
      b_prev_sclk = if_b.sclk;
      if (if_b.done) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_done: got done=1 want no frame (cycle %0d)", cyc);
        end else begin
          e_b = exp_b.pop_front();
          chk("b_rx_data", 32'(if_b.rx_data), 32'(e_b.rx));
          chk("b_done_cycle", cyc, e_b.done_cyc);
          chk("b_sclk_rises", b_rises, DW_B + 1);
          chk("b_mosi_stream", b_obs, 32'({e_b.tx, 1'b0}));
        end
        b_rises = 0; b_obs = 0;
      end
    end
  end

  task automatic wait_idle_a();
    int g = 0;
    while (if_a.busy && g < 200) begin
      tick();
      g++;
    end
    chk("a_idle_wait", 32'(if_a.busy), 32'd0);
  endtask

  task automatic wait_idle_b();
    int g = 0;
    while (if_b.busy && g < 200) begin
      tick();
      g++;
    end
    chk("b_idle_wait", 32'(if_b.busy), 32'd0);
  endtask

  function automatic exp_t model_a(input logic [3:0] tx, input logic loop, input logic cval, input int dcyc);
    exp_t r;
    r.tx = {4'd0, tx};
    r.rx = loop ? {4'd0, tx} : (cval ? 8'h0F : 8'h00);
    r.done_cyc = dcyc;
    return r;
  endfunction

  task automatic send_a(input logic [3:0] tx, input logic loop, input logic cval);
    wait_idle_a();
    a_loop = loop;
    a_const = cval;
    if_a.tx_data = tx;
    if_a.start = 1'b1;
    exp_a.push_back(model_a(tx, loop, cval, cyc + T_A));
    tick();
    if_a.start = 1'b0;
    if_a.tx_data = 4'($urandom);
  endtask

  task automatic send_b(input logic [7:0] tx, input logic loop, input logic cval);
    exp_t r;
    wait_idle_b();
    b_loop = loop;
    b_const = cval;
    if_b.tx_data = tx;
    if_b.start = 1'b1;
    r.tx = tx;
    r.rx = loop ? tx : {8{cval}};
    r.done_cyc = cyc + T_B;
    exp_b.push_back(r);
    tick();
    if_b.start = 1'b0;
    if_b.tx_data = 8'($urandom);
  endtask

  // Start held high: the second frame is accepted the cycle after done.
  task automatic back_to_back(input logic [3:0] tx);
    int c;
    int gap = 0;
    wait_idle_a();
    a_loop = 1'b1;
    c = cyc;
    if_a.tx_data = tx;
    if_a.start = 1'b1;
    exp_a.push_back(model_a(tx, 1'b1, 1'b0, c + T_A));
    exp_a.push_back(model_a(tx, 1'b1, 1'b0, c + 2 * T_A + 1));
    for (int i = 1; i <= T_A + 2; i++) begin
      tick();
      if (i >= 2 && if_a.select) gap++;
    end
    if_a.start = 1'b0;
    chk("b2b_second_frame_busy", 32'(if_a.busy), 32'd1);
    // select is high in the DONE cycle and in the IDLE cycle that accepts start.
    chk("b2b_select_gap", gap, 2);
  endtask

  // Start pulses mid-frame and during DONE must not queue another frame.
  task automatic ignored_pulses(input logic [3:0] tx);
    wait_idle_a();
    a_loop = 1'b1;
    if_a.tx_data = tx;
    if_a.start = 1'b1;
    exp_a.push_back(model_a(tx, 1'b1, 1'b0, cyc + T_A));
    for (int i = 1; i <= T_A + 2; i++) begin
      tick();
      if_a.start = (i == 5 || i == T_A);
      if_a.tx_data = 4'($urandom);
    end
    chk("no_requeue_busy", 32'(if_a.busy), 32'd0);
  endtask

  task automatic reset_abort(input logic [3:0] tx);
    wait_idle_a();
    a_loop = 1'b1;
    if_a.tx_data = tx;
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    chk("abort_sclk", 32'(if_a.sclk), 32'd0);
    chk("abort_mosi", 32'(if_a.mosi), 32'd0);
    chk("abort_select", 32'(if_a.select), 32'd1);
    chk("abort_busy", 32'(if_a.busy), 32'd0);
    chk("abort_done", 32'(if_a.done), 32'd0);
    chk("abort_rx_data", 32'(if_a.rx_data), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_loop = 1'b1; a_const = 1'b0; b_loop = 1'b1; b_const = 1'b0;
    if_a.start = 1'b0; if_a.tx_data = '0;
    if_b.start = 1'b0; if_b.tx_data = '0;
    repeat (3) tick();
    chk("rst_select", 32'(if_a.select), 32'd1);
    chk("rst_sclk", 32'(if_a.sclk), 32'd0);
    chk("rst_mosi", 32'(if_a.mosi), 32'd0);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_done", 32'(if_a.done), 32'd0);
    chk("rst_rx_data", 32'(if_a.rx_data), 32'd0);
    chk("rst_b_select", 32'(if_b.select), 32'd1);
    rst = 1'b0;
    tick();

    send_a(4'b1011, 1'b1, 1'b0);
    send_a(4'b0110, 1'b1, 1'b0);
    send_a(4'b0110, 1'b0, 1'b1);
    back_to_back(4'b1001);
    ignored_pulses(4'b0101);
    reset_abort(4'b1110);
    send_a(4'b1101, 1'b1, 1'b0);
    repeat (12) send_a(4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_idle_a();

    send_b(8'hA5, 1'b1, 1'b0);
    send_b(8'h3C, 1'b0, 1'b1);
    repeat (5) send_b(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    for (int g = 0; g < 2000 && (exp_a.size() + exp_b.size()) > 0; g++) tick();
    chk("scoreboard_drain", exp_a.size() + exp_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
